ex_flags_stage: RTL and testbench

- Sits directly downstream of the 64-bit ALU built from aluBit slices; consumes the ALU result, carry-out and overflow.
- Derives NZCV and holds the architectural flag register, written by flag-setting ops (ADDS/SUBS/ANDS).
- Evaluates B.cond conditions with same-cycle flag forwarding.
- Registers the result and control into the EX/MEM pipeline boundary, with stall and flush.

---
 rtl/ex_pkg.sv | 43 ++++
 rtl/cond_eval.sv | 35 +++
 rtl/ex_flags_stage.sv | 102 ++++++++++
 tb/tb_ex_flags_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the EX flag stage: ALU op codes, branch condition codes
// and the NZCV flag struct.
package ex_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Only the arithmetic ops produce a meaningful carry and overflow.
  function automatic logic op_sets_cv(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: maps a flag set and a condition code to
// taken / not taken. Shared with the branch unit.
module cond_eval
  import ex_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   cond_true
);

  // Condition table; both 0xE and 0xF mean "always".
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = flags.z;
      COND_NE: cond_true = ~flags.z;
      COND_HS: cond_true = flags.c;
      COND_LO: cond_true = ~flags.c;
      COND_MI: cond_true = flags.n;
      COND_PL: cond_true = ~flags.n;
      COND_VS: cond_true = flags.v;
      COND_VC: cond_true = ~flags.v;
      COND_HI: cond_true = flags.c & ~flags.z;
      COND_LS: cond_true = ~flags.c | flags.z;
      COND_GE: cond_true = (flags.n == flags.v);
      COND_LT: cond_true = (flags.n != flags.v);
      COND_GT: cond_true = ~flags.z & (flags.n == flags.v);
      COND_LE: cond_true = flags.z | (flags.n != flags.v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flags_stage.sv
// EX-stage tail: derives NZCV from the ALU outputs, holds the architectural
// flag register, evaluates B.cond with same-cycle forwarding and registers
// the EX/MEM pipeline boundary.
//
// Pipeline control: valid_in marks a real instruction in EX. flush kills it
// (bubble enters EX/MEM) and wins over stall; stall freezes EX/MEM and
// blocks the flag write, but forwarding to cond_true still sees the
// instruction's flags so a dependent branch resolves the same cycle.
module ex_flags_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic [2:0]       alu_op,
  input  logic             valid_in,
  input  logic             set_flags,
  input  logic [REGW-1:0]  rd_in,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic             zero_now,
  output logic [3:0]       flags_q,
  output logic             valid_q,
  output logic [WIDTH-1:0] result_q,
  output logic [REGW-1:0]  rd_q,
  output logic             reg_write_q,
  output logic             mem_read_q,
  output logic             mem_write_q
);

  flags_t new_flags;
  flags_t eff_flags;
  flags_t flags_r;
  logic   fwd;
  logic   upd;

  // Flags this instruction would produce; C/V only meaningful for ADD/SUB.
  always_comb begin
    new_flags.n = alu_result[WIDTH-1];
    new_flags.z = ~|alu_result;
    new_flags.c = op_sets_cv(alu_op) & alu_cout;
    new_flags.v = op_sets_cv(alu_op) & alu_ovf;
  end

  assign fwd       = valid_in & set_flags & ~flush;
  assign upd       = fwd & ~stall;
  assign eff_flags = fwd ? new_flags : flags_r;
  assign zero_now  = new_flags.z;
  assign flags_q   = flags_r;

  cond_eval u_cond_eval (
    .flags     (eff_flags),
    .cond      (cond_e'(cond)),
    .cond_true (cond_true)
  );

  // Architectural NZCV register: written only by unstalled flag-setting ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_r <= '0;
    end else if (upd) begin
      flags_r <= new_flags;
    end
  end

  // EX/MEM boundary: flush inserts a bubble, stall holds, else capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      result_q    <= alu_result;
      rd_q        <= rd_in;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= valid_in;
      result_q    <= alu_result;
      rd_q        <= rd_in;
      reg_write_q <= reg_write_in & valid_in;
      mem_read_q  <= mem_read_in & valid_in;
      mem_write_q <= mem_write_in & valid_in;
    end
  end

endmodule

// File: tb/tb_ex_flags_stage.sv
// Self-checking bench for ex_flags_stage: directed scenarios, a condition
// sweep and randomized ALU traffic against a behavioural model.
module tb_ex_flags_stage;

  logic        clk;
  logic        reset;
  logic [63:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;
  logic [2:0]  alu_op;
  logic        valid_in;
  logic        set_flags;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        stall;
  logic        flush;
  logic [3:0]  cond;
  logic        cond_true;
  logic        zero_now;
  logic [3:0]  flags_q;
  logic        valid_q;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;

  int errors = 0;
  int checks = 0;

  // Model state ({n,z,c,v} and EX/MEM contents)
  logic [3:0]  m_flags;
  logic        m_valid;
  logic [63:0] m_result;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_mr;
  logic        m_mw;
  logic        m_known;

  ex_flags_stage #(.WIDTH(64), .REGW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .alu_ovf      (alu_ovf),
    .alu_op       (alu_op),
    .valid_in     (valid_in),
    .set_flags    (set_flags),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .stall        (stall),
    .flush        (flush),
    .cond         (cond),
    .cond_true    (cond_true),
    .zero_now     (zero_now),
    .flags_q      (flags_q),
    .valid_q      (valid_q),
    .result_q     (result_q),
    .rd_q         (rd_q),
    .reg_write_q  (reg_write_q),
    .mem_read_q   (mem_read_q),
    .mem_write_q  (mem_write_q)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM-style condition evaluation: base test on cond[3:1], cond[0] inverts.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = (n == v) && !z;
      default: b = 1'b1;
    endcase
    if (c[0] && c != 4'hF) b = !b;
    return b;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [63:0] res, input logic [2:0] op,
                                           input logic co, input logic ov);
    logic arith;
    arith = (op == 3'd2) || (op == 3'd3);
    return {res[63], res == 64'd0, arith && co, arith && ov};
  endfunction

  // One cycle: check combinational outputs, clock, update model, check registers.
  task automatic step(input string tag);
    logic [3:0] nf;
    logic [3:0] eff;
    logic       fwd;
    @(negedge clk);
    #1;
    if (!reset) begin
      m_flags = 4'h0; m_valid = 0; m_result = '0; m_rd = '0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_known = 1;
    end
    nf  = ref_flags(alu_result, alu_op, alu_cout, alu_ovf);
    fwd = valid_in && set_flags && !flush;
    eff = fwd ? nf : m_flags;
    check({tag, ".cond_true"}, cond_true, ref_cond(eff, cond));
    check({tag, ".zero_now"}, zero_now, alu_result == 64'd0);
    @(posedge clk);
    if (reset) begin
      if (fwd && !stall) m_flags = nf;
      if (flush) begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_known = 0;
      end else if (!stall) begin
        m_valid = valid_in; m_result = alu_result; m_rd = rd_in;
        m_rw = reg_write_in && valid_in;
        m_mr = mem_read_in && valid_in;
        m_mw = mem_write_in && valid_in;
        m_known = 1;
      end
    end
    #1;
    check({tag, ".flags_q"}, flags_q, m_flags);
    check({tag, ".valid_q"}, valid_q, m_valid);
    check({tag, ".reg_write_q"}, reg_write_q, m_rw);
    check({tag, ".mem_read_q"}, mem_read_q, m_mr);
    check({tag, ".mem_write_q"}, mem_write_q, m_mw);
    if (m_known) begin
      check({tag, ".result_q"}, result_q, m_result);
      check({tag, ".rd_q"}, rd_q, m_rd);
    end
  endtask

  // Random ALU op with arithmetically consistent result/carry/overflow.
  task automatic rand_alu();
    logic [63:0] a, b;
    logic [64:0] s;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    alu_op = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 5) == 0) b = a;
    alu_cout = 1'($urandom);
    alu_ovf  = 1'($urandom);
    case (alu_op)
      3'd0: alu_result = b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        alu_result = s[63:0]; alu_cout = s[64];
        alu_ovf = (a[63] == b[63]) && (s[63] != a[63]);
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        alu_result = s[63:0]; alu_cout = s[64];
        alu_ovf = (a[63] != b[63]) && (s[63] != a[63]);
      end
      3'd4: alu_result = a & b;
      3'd5: alu_result = a | b;
      3'd6: alu_result = a ^ b;
      default: alu_result = a;
    endcase
  endtask

  task automatic rand_ctrl();
    valid_in     = ($urandom_range(0, 3) != 0);
    set_flags    = 1'($urandom);
    rd_in        = 5'($urandom);
    reg_write_in = 1'($urandom);
    mem_read_in  = 1'($urandom);
    mem_write_in = 1'($urandom);
    stall        = ($urandom_range(0, 5) == 0);
    flush        = ($urandom_range(0, 7) == 0);
    cond         = 4'($urandom);
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] res, input logic co,
                       input logic ov, input logic sf, input logic [3:0] cc);
    alu_op = op; alu_result = res; alu_cout = co; alu_ovf = ov;
    set_flags = sf; cond = cc;
    valid_in = 1; stall = 0; flush = 0;
    rd_in = 5'd1; reg_write_in = 1; mem_read_in = 0; mem_write_in = 0;
  endtask

  initial begin
    m_flags = 0; m_valid = 0; m_result = 0; m_rd = 0;
    m_rw = 0; m_mr = 0; m_mw = 0; m_known = 1;
    reset = 1'b0;
    rand_alu();
    rand_ctrl();

    // Reset held with random activity
    for (int i = 0; i < 3; i++) begin
      rand_alu(); rand_ctrl();
      valid_in = 1; set_flags = 1; stall = 0; flush = 0;
      step("reset_hold");
    end

    // Release; ADDS 5 + (-5) -> 0110
    @(negedge clk);
    reset = 1'b1;
    drive(3'b010, 64'd0, 1'b1, 1'b0, 1'b1, 4'h0);
    step("adds_zero");
    check("adds_zero.flags", flags_q, 4'b0110);

    // SUBS overflow with LT: forwarded N=1,V=1 -> not taken
    drive(3'b011, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 4'hB);
    step("subs_ovf");
    check("subs_ovf.flags", flags_q, 4'b1001);

    // Load 0011, then ANDS clears C,V
    drive(3'b010, 64'd1, 1'b1, 1'b1, 1'b1, 4'hE);
    step("load_0011");
    check("load_0011.flags", flags_q, 4'b0011);
    drive(3'b100, 64'd0, 1'b1, 1'b1, 1'b1, 4'h0);
    step("ands");
    check("ands.flags", flags_q, 4'b0100);
    drive(3'b010, 64'd42, 1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    check("add_noset.cond_eq", cond_true, 1'b1);
    step("add_noset");
    check("add_noset.flags", flags_q, 4'b0100);

    // Stalled SUBS: no flag write, registers held, forwarding still active
    drive(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'h4);
    stall = 1; mem_write_in = 1;
    #1;
    check("stall.cond_fwd", cond_true, 1'b1);
    step("stall_subs");
    check("stall.flags", flags_q, 4'b0100);

    // Flush with stall: bubble, no flag write
    drive(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'h4);
    stall = 1; flush = 1; mem_write_in = 1;
    step("flush_stall");
    check("flush.valid_q", valid_q, 1'b0);
    check("flush.mem_write_q", mem_write_q, 1'b0);
    check("flush.flags", flags_q, 4'b0100);

    // Condition sweep over every reachable flag value (N and Z never both set)
    for (int f = 0; f < 16; f++) begin
      logic [3:0] fv;
      fv = 4'(f);
      if (fv[3] && fv[2]) continue;
      drive(3'b010, fv[3] ? 64'h8000_0000_0000_0000 : (fv[2] ? 64'd0 : 64'd3),
            fv[1], fv[0], 1'b1, 4'hE);
      step("sweep_load");
      for (int c = 0; c < 16; c++) begin
        rand_alu(); rand_ctrl();
        set_flags = 0; cond = 4'(c);
        step("sweep");
      end
    end

    // Pipeline pass-through
    drive(3'b000, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'hE);
    rd_in = 5'd7;
    step("pipe_valid");
    check("pipe.result_q", result_q, 64'hDEAD_BEEF);
    check("pipe.rd_q", rd_q, 5'd7);
    check("pipe.reg_write_q", reg_write_q, 1'b1);
    drive(3'b000, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 4'hE);
    rd_in = 5'd7; valid_in = 0;
    step("pipe_invalid");
    check("pipe_inv.reg_write_q", reg_write_q, 1'b0);

    // Random traffic with one mid-stream reset pulse
    for (int i = 0; i < 400; i++) begin
      rand_alu(); rand_ctrl();
      reset = (i >= 200 && i < 202) ? 1'b0 : 1'b1;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
